// File: rtl/wb_uart_bridge.sv
// UART-to-Wishbone bridge: 'W' + 4 address + 4 data bytes, or 'R' + 4 address bytes,
// runs one single-beat bus cycle and returns 'K', 'E' or four read-data bytes.
module wb_uart_bridge #(
  parameter int unsigned WB_TIMEOUT = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_byte_o,
  output logic        tx_start_o,
  input  logic        tx_done_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic [31:0] wb_dat_i,
  output logic        busy_o
);

  localparam logic [10:0] TmoLast = 11'(WB_TIMEOUT - 1);
  localparam logic [7:0]  CmdWrite = 8'h57;
  localparam logic [7:0]  CmdRead  = 8'h52;
  localparam logic [7:0]  RespOk   = 8'h4B;
  localparam logic [7:0]  RespErr  = 8'h45;

  typedef enum logic [2:0] {
    StIdle,
    StGetAdr,
    StGetDat,
    StBus,
    StSend,
    StTxWait
  } state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] resp_q, resp_d;
  logic [10:0] tmo_q, tmo_d;
  logic        seen_q, seen_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [31:0] wb_adr_q, wb_adr_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic        wb_we_q, wb_we_d;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wr_q      <= 1'b0;
      cnt_q     <= 3'd0;
      adr_q     <= 32'h0;
      dat_q     <= 32'h0;
      resp_q    <= 32'h0;
      tmo_q     <= 11'd0;
      seen_q    <= 1'b0;
      tx_byte_q <= 8'h0;
      wb_adr_q  <= 32'h0;
      wb_dat_q  <= 32'h0;
      wb_we_q   <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      resp_q    <= resp_d;
      tmo_q     <= tmo_d;
      seen_q    <= seen_d;
      tx_byte_q <= tx_byte_d;
      wb_adr_q  <= wb_adr_d;
      wb_dat_q  <= wb_dat_d;
      wb_we_q   <= wb_we_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    resp_d    = resp_q;
    tmo_d     = tmo_q;
    seen_d    = seen_q;
    tx_byte_d = tx_byte_q;
    wb_adr_d  = wb_adr_q;
    wb_dat_d  = wb_dat_q;
    wb_we_d   = wb_we_q;

    unique case (state_q)
      StIdle: begin
        if (rx_valid_i && (rx_byte_i == CmdWrite || rx_byte_i == CmdRead)) begin
          wr_d    = (rx_byte_i == CmdWrite);
          cnt_d   = 3'd0;
          state_d = StGetAdr;
        end
      end
      StGetAdr: begin
        if (rx_valid_i) begin
          adr_d = {adr_q[23:0], rx_byte_i};
          if (cnt_q == 3'd3) begin
            cnt_d   = 3'd0;
            state_d = wr_q ? StGetDat : StBus;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      StGetDat: begin
        if (rx_valid_i) begin
          dat_d = {dat_q[23:0], rx_byte_i};
          if (cnt_q == 3'd3) begin
            cnt_d   = 3'd0;
            state_d = StBus;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      StBus: begin
        // Error beats ack; timeout is treated like an error.
        if (wb_err_i || tmo_q == TmoLast) begin
          resp_d  = {RespErr, 24'h0};
          cnt_d   = 3'd1;
          state_d = StSend;
        end else if (wb_ack_i) begin
          resp_d  = wr_q ? {RespOk, 24'h0} : wb_dat_i;
          cnt_d   = wr_q ? 3'd1 : 3'd4;
          state_d = StSend;
        end else if (tmo_q != 11'h7FF) begin
          tmo_d = tmo_q + 11'd1;
        end
      end
      StSend: begin
        cnt_d   = cnt_q - 3'd1;
        seen_d  = 1'b0;
        state_d = StTxWait;
      end
      StTxWait: begin
        if (!seen_q) begin
          seen_d = tx_done_i;
        end else if (!tx_done_i) begin
          state_d = (cnt_q != 3'd0) ? StSend : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Bus-facing registers only change on BUS entry so they hold outside it.
    if (state_d == StBus && state_q != StBus) begin
      wb_adr_d = adr_d;
      wb_dat_d = dat_d;
      wb_we_d  = wr_q;
      tmo_d    = 11'd0;
    end

    if (state_d == StSend && state_q != StSend) begin
      tx_byte_d = resp_d[31:24];
      resp_d    = {resp_d[23:0], 8'h00};
    end
  end

  assign wb_cyc_o   = (state_q == StBus);
  assign wb_stb_o   = (state_q == StBus);
  assign wb_sel_o   = (state_q == StBus) ? 4'hF : 4'h0;
  assign wb_we_o    = wb_we_q;
  assign wb_adr_o   = wb_adr_q;
  assign wb_dat_o   = wb_dat_q;
  assign tx_byte_o  = tx_byte_q;
  assign tx_start_o = (state_q == StSend);
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_wb_uart_bridge.sv
// Directed bench for wb_uart_bridge: write, read, error, timeout, noise and mid-command reset.
module tb_wb_uart_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_done;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_uart_bridge #(.WB_TIMEOUT(16)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst_n),
    .rx_byte_i  (rx_byte),
    .rx_valid_i (rx_valid),
    .tx_byte_o  (tx_byte),
    .tx_start_o (tx_start),
    .tx_done_i  (tx_done),
    .wb_cyc_o   (wb_cyc),
    .wb_stb_o   (wb_stb),
    .wb_we_o    (wb_we),
    .wb_adr_o   (wb_adr),
    .wb_dat_o   (wb_dat_w),
    .wb_sel_o   (wb_sel),
    .wb_ack_i   (wb_ack),
    .wb_err_i   (wb_err),
    .wb_dat_i   (wb_dat_r),
    .busy_o     (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Waits for a bus cycle, checks its qualifiers, then terminates it (or lets it time out).
  task automatic bus_txn(input string tag, input logic exp_we, input logic [31:0] exp_adr,
                         input logic [31:0] exp_dat, input logic ack, input logic err,
                         input logic [31:0] rdata, input int exp_len);
    int n = 0;
    while (!wb_cyc && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_cyc"}, 32'(wb_cyc), 32'd1);
    check_eq({tag, "_stb"}, 32'(wb_stb), 32'd1);
    check_eq({tag, "_sel"}, 32'(wb_sel), 32'hF);
    check_eq({tag, "_we"}, 32'(wb_we), 32'(exp_we));
    check_eq({tag, "_adr"}, wb_adr, exp_adr);
    if (exp_we) check_eq({tag, "_dat"}, wb_dat_w, exp_dat);
    if (ack || err) begin
      @(negedge clk);
      check_eq({tag, "_cyc_held"}, 32'(wb_cyc), 32'd1);
      wb_ack   = ack;
      wb_err   = err;
      wb_dat_r = rdata;
      @(negedge clk);
      wb_ack   = 1'b0;
      wb_err   = 1'b0;
      wb_dat_r = 32'hFFFF_FFFF;
      check_eq({tag, "_cyc_drop"}, 32'(wb_cyc), 32'd0);
    end else begin
      n = 0;
      while (wb_cyc && n < 100) begin
        @(negedge clk);
        n++;
      end
      check_eq({tag, "_tmo_len"}, 32'(n), 32'(exp_len));
    end
  endtask

  // Acts as the transmitter: collects nbytes, checks order and handshake spacing.
  task automatic tx_expect(input string tag, input int nbytes, input logic [31:0] exp);
    int early = 0;
    int extra = 0;
    for (int i = 0; i < nbytes; i++) begin
      int n = 0;
      while (!tx_start && n < 50) begin
        @(negedge clk);
        n++;
      end
      check_eq({tag, "_start"}, 32'(tx_start), 32'd1);
      check_eq({tag, "_byte"}, 32'(tx_byte), 32'(exp[31 - 8 * i -: 8]));
      @(negedge clk);
      if (tx_start) early++;
      tx_done = 1'b1;
      repeat (2) begin
        @(negedge clk);
        if (tx_start) early++;
      end
      tx_done = 1'b0;
    end
    check_eq({tag, "_early_start"}, 32'(early), 32'd0);
    repeat (10) begin
      @(negedge clk);
      if (tx_start) extra++;
    end
    check_eq({tag, "_extra_start"}, 32'(extra), 32'd0);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    tx_done  = 1'b0;
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_dat_r = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cyc", 32'(wb_cyc), 32'd0);
    check_eq("rst_start", 32'(tx_start), 32'd0);
    check_eq("rst_adr", wb_adr, 32'h0);
    check_eq("rst_sel", 32'(wb_sel), 32'h0);
    check_eq("rst_txbyte", 32'(tx_byte), 32'h0);
    rst_n = 1'b1;

    // Write with ack.
    send_byte(8'h57);
    check_eq("wr_busy", 32'(busy), 32'd1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h04);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    bus_txn("wr", 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 0);
    tx_expect("wr_tx", 1, 32'h4B00_0000);
    check_eq("wr_adr_hold", wb_adr, 32'h0000_1004);
    check_eq("wr_we_hold", 32'(wb_we), 32'd1);

    // Read with ack; read data latched in the ack cycle.
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    bus_txn("rd", 1'b0, 32'h0000_1000, 32'h0, 1'b1, 1'b0, 32'h0000_3A00, 0);
    tx_expect("rd_tx", 4, 32'h0000_3A00);

    // Error and ack together: error wins.
    send_byte(8'h57);
    send_byte(8'hA0); send_byte(8'hB0); send_byte(8'hC0); send_byte(8'hD0);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    bus_txn("err", 1'b1, 32'hA0B0_C0D0, 32'h0102_0304, 1'b1, 1'b1, 32'h0, 0);
    tx_expect("err_tx", 1, 32'h4500_0000);

    // Read that times out after 16 cycles.
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
    bus_txn("tmo", 1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 32'h0, 16);
    tx_expect("tmo_tx", 1, 32'h4500_0000);

    // Noise in IDLE is ignored.
    send_byte(8'h00);
    check_eq("noise00_busy", 32'(busy), 32'd0);
    send_byte(8'hFF);
    check_eq("noiseFF_busy", 32'(busy), 32'd0);

    // Reset after two address bytes.
    send_byte(8'h57);
    send_byte(8'h11); send_byte(8'h22);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_adr", wb_adr, 32'h0);
    check_eq("midrst_we", 32'(wb_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send_byte(8'h57);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
    bus_txn("post", 1'b1, 32'h1234_5678, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0, 0);
    tx_expect("post_tx", 1, 32'h4B00_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
